insn_prefetch_buffer: RTL

Instruction prefetch queue between the SPI program-memory word fetcher and the CPU decode path. Requests consecutive 16-bit words ahead of the program counter and holds up to DEPTH of them, so sequential execution hides SPI latency. The queue flushes whenever the CPU presents a non-sequential address, such as a taken branch. On the CPU side it replaces the direct `instruction`/`ready` connection of the program memory.

---
 rtl/insn_prefetch_buffer_pkg.sv | 11 +
 rtl/insn_fifo.sv | 44 ++++
 rtl/insn_prefetch_buffer.sv | 98 +++++++++
 3 files changed

// File: rtl/insn_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch buffer: default depth and FSM states.
package insn_prefetch_buffer_pkg;

  localparam int PF_DEPTH = 4;

  typedef enum logic {
    PF_IDLE = 1'b0,
    PF_REQ  = 1'b1
  } pf_state_e;

endpackage

// File: rtl/insn_fifo.sv
// Small circular instruction queue with flush and a combinational head word (zero when empty).
module insn_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DW-1:0]           wdata,
  output logic [DW-1:0]           head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

  assign head  = (count_q != '0) ? mem[rd_ptr] : '0;
  assign count = count_q;

endmodule

// File: rtl/insn_prefetch_buffer.sv
// Prefetch queue between the SPI word fetcher and CPU decode; flushes on any non-sequential PC.
module insn_prefetch_buffer
  import insn_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_take,
  output logic [DW-1:0] cpu_insn,
  output logic          cpu_ready,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_e     state;
  logic [AW-1:0] head_addr;
  logic [AW-1:0] fetch_addr;
  logic          discard;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          miss;
  logic          pop;
  logic          push;

  assign miss        = (cpu_addr != head_addr);
  assign cpu_ready   = (count != '0) && !miss;
  assign pop         = cpu_take && cpu_ready;
  assign push        = (state == PF_REQ) && mem_ack && !discard && !miss;
  assign count_after = count - CW'(pop);

  insn_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (miss),
    .wdata (mem_data),
    .head  (cpu_insn),
    .count (count)
  );

  // A miss retargets both address registers; a word already in flight for the
  // old stream is marked for discard so it never lands in the new stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PF_IDLE;
      head_addr  <= '0;
      fetch_addr <= '0;
      discard    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      if (miss) begin
        head_addr  <= cpu_addr;
        fetch_addr <= cpu_addr;
      end else begin
        if (pop)  head_addr  <= head_addr + AW'(1);
        if (push) fetch_addr <= fetch_addr + AW'(1);
      end

      case (state)
        PF_IDLE: begin
          if (miss) begin
            state    <= PF_REQ;
            mem_req  <= 1'b1;
            mem_addr <= cpu_addr;
          end else if (count_after < CW'(DEPTH)) begin
            state    <= PF_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        end
        PF_REQ: begin
          if (mem_ack) begin
            state   <= PF_IDLE;
            mem_req <= 1'b0;
            discard <= miss;
          end else if (miss) begin
            discard <= 1'b1;
          end
        end
        default: state <= PF_IDLE;
      endcase
    end
  end

endmodule
